// File: rtl/hamming_secded_rx_pkg.sv
// Shared SECDED Hamming helpers: parity-count sizing, codeword position
// mapping and the decode outcome encoding. Also used by the matching encoder.
package hamming_secded_rx_pkg;

    // Outcome of decoding one received frame.
    typedef enum logic [1:0] {
        DEC_CLEAN  = 2'd0,
        DEC_CORR   = 2'd1,
        DEC_UNCORR = 2'd2
    } dec_e;

    // Smallest r with 2**r >= m + r + 1 (number of Hamming parity bits).
    function automatic int calc_r(input int m);
        int r;
        r = 1;
        for (int k = 0; k < 30; k++) begin
            if ((1 << r) < m + r + 1) r = r + 1;
        end
        return r;
    endfunction

    // Parity bits live at the power-of-two positions.
    function automatic logic is_pow2(input int p);
        return (p > 0) && ((p & (p - 1)) == 0);
    endfunction

    // Codeword position of data bit i: the i-th non-power-of-two position.
    function automatic int data_pos(input int i);
        int pos;
        int cnt;
        pos = 0;
        cnt = -1;
        for (int p = 1; p < 1024; p++) begin
            if (!is_pow2(p) && (cnt < i)) begin
                cnt = cnt + 1;
                pos = p;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_secded_rx_if.sv
// Serial link side (bit_in/shift/sync) and decoded word side of the decoder.
// Handshake: a bit is transferred on every rising clk edge where shift=1;
// valid is a one-cycle pulse, there is no back-pressure on the output.
interface hamming_secded_rx_if #(parameter int M = 4);
    logic         bit_in;
    logic         shift;
    logic         sync;
    logic [M-1:0] data_out;
    logic         valid;
    logic         err_corr;
    logic         err_uncorr;
    logic         busy;

    modport master (
        output bit_in, shift, sync,
        input  data_out, valid, err_corr, err_uncorr, busy
    );

    modport slave (
        input  bit_in, shift, sync,
        output data_out, valid, err_corr, err_uncorr, busy
    );
endinterface

// File: rtl/hamming_secded_rx_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt
);
    localparam logic [CW-1:0] MAX = '1;

    // Count up to all-ones and stick there until cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/hamming_secded_rx.sv
// Serial-in SECDED Hamming decoder. Bits arrive p1..p(N-1) then p0; the
// syndrome and overall parity are accumulated on the fly and the frame is
// decoded on the edge that samples its last bit.
module hamming_secded_rx
    import hamming_secded_rx_pkg::*;
#(
    parameter int M  = 4,
    parameter int CW = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    hamming_secded_rx_if.slave   link,
    input  logic                 clr_cnt,
    output logic [CW-1:0]        corr_cnt,
    output logic [CW-1:0]        uncorr_cnt
);
    localparam int R = calc_r(M);
    localparam int N = M + R + 1;
    // N always needs exactly R index bits, so R-bit counter/syndrome suffice.
    localparam logic [R-1:0] LAST_CNT = R'(N - 1);
    localparam logic [R:0]   MAX_POS  = (R + 1)'(N - 1);
    localparam logic [N-1:0] ONE_HOT0 = N'(1);

    logic [R-1:0] bit_cnt, cnt_base, cnt_nxt, pos;
    logic [R-1:0] syn, syn_base, syn_nxt;
    logic         par, par_base, par_nxt;
    logic [N-1:0] cw, cw_nxt, fixed;
    logic         last_bit;
    logic [M-1:0] dec_data;
    dec_e         status;
    logic [M-1:0] data_q;
    logic         valid_q, corr_q, uncorr_q;

    // Accumulate the incoming bit; sync restarts the frame before this bit.
    always_comb begin
        cnt_base = link.sync ? '0 : bit_cnt;
        syn_base = link.sync ? '0 : syn;
        par_base = link.sync ? 1'b0 : par;
        last_bit = link.shift && (cnt_base == LAST_CNT);
        pos      = last_bit ? '0 : cnt_base + R'(1);
        syn_nxt  = syn_base ^ ((link.shift && link.bit_in) ? pos : '0);
        par_nxt  = par_base ^ (link.shift & link.bit_in);
        cw_nxt   = cw;
        if (link.shift) cw_nxt[pos] = link.bit_in;
        cnt_nxt  = cnt_base;
        if (link.shift) cnt_nxt = last_bit ? '0 : cnt_base + R'(1);
    end

    // Classify the completed frame and apply the single-bit correction.
    always_comb begin
        status = DEC_UNCORR;
        fixed  = cw_nxt;
        if (syn_nxt == '0) begin
            status = par_nxt ? DEC_CORR : DEC_CLEAN;
        end else if (par_nxt && ({1'b0, syn_nxt} <= MAX_POS)) begin
            status = DEC_CORR;
            fixed  = cw_nxt ^ (ONE_HOT0 << syn_nxt);
        end
    end

    for (genvar gi = 0; gi < M; gi++) begin : g_extract
        localparam int DP = data_pos(gi);
        assign dec_data[gi] = fixed[DP];
    end

    // Frame state and registered decode results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt  <= '0;
            syn      <= '0;
            par      <= 1'b0;
            cw       <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            corr_q   <= 1'b0;
            uncorr_q <= 1'b0;
        end else begin
            bit_cnt <= cnt_nxt;
            syn     <= last_bit ? '0 : syn_nxt;
            par     <= last_bit ? 1'b0 : par_nxt;
            cw      <= cw_nxt;
            valid_q <= last_bit;
            if (last_bit) begin
                data_q   <= dec_data;
                corr_q   <= (status == DEC_CORR);
                uncorr_q <= (status == DEC_UNCORR);
            end
        end
    end

    assign link.data_out   = data_q;
    assign link.valid      = valid_q;
    assign link.err_corr   = corr_q;
    assign link.err_uncorr = uncorr_q;
    assign link.busy       = (bit_cnt != '0);

    sat_counter #(.CW(CW)) u_corr_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (last_bit && (status == DEC_CORR)),
        .clr   (clr_cnt),
        .cnt   (corr_cnt)
    );

    sat_counter #(.CW(CW)) u_uncorr_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (last_bit && (status == DEC_UNCORR)),
        .clr   (clr_cnt),
        .cnt   (uncorr_cnt)
    );
endmodule

// File: tb/tb_hamming_secded_rx.sv
// Bench for hamming_secded_rx: M=4/CW=8 main instance, M=4/CW=2 for
// saturation (same stimulus), M=5 instance for out-of-range syndromes.
module tb_hamming_secded_rx;
    logic       clk;
    logic       reset;
    logic       clr_cnt;
    logic [7:0] corr_a, uncorr_a, corr_c, uncorr_c;
    logic [1:0] corr_b, uncorr_b;

    hamming_secded_rx_if #(.M(4)) if_a ();
    hamming_secded_rx_if #(.M(4)) if_b ();
    hamming_secded_rx_if #(.M(5)) if_c ();

    hamming_secded_rx #(.M(4), .CW(8)) dut_a (
        .clk(clk), .reset(reset), .link(if_a.slave), .clr_cnt(clr_cnt),
        .corr_cnt(corr_a), .uncorr_cnt(uncorr_a)
    );
    hamming_secded_rx #(.M(4), .CW(2)) dut_b (
        .clk(clk), .reset(reset), .link(if_b.slave), .clr_cnt(clr_cnt),
        .corr_cnt(corr_b), .uncorr_cnt(uncorr_b)
    );
    hamming_secded_rx #(.M(5), .CW(8)) dut_c (
        .clk(clk), .reset(reset), .link(if_c.slave), .clr_cnt(clr_cnt),
        .corr_cnt(corr_c), .uncorr_cnt(uncorr_c)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int vcount = 0;
    int c8 = 0, u8 = 0, c2 = 0, u2 = 0;
    logic [5:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference encoder: codeword indexed by position, p0 = overall parity.
    function automatic logic [15:0] enc(input int m, input logic [15:0] d);
        int r, n, pos;
        logic [15:0] cw;
        logic x;
        r = 1;
        while ((1 << r) < m + r + 1) r++;
        n = m + r + 1;
        cw = '0;
        pos = 1;
        for (int i = 0; i < m; i++) begin
            while ((pos & (pos - 1)) == 0) pos++;
            cw[pos] = d[i];
            pos++;
        end
        for (int j = 0; j < r; j++) begin
            x = 1'b0;
            for (int p = 1; p < n; p++)
                if ((((p >> j) & 1) == 1) && (p != (1 << j))) x = x ^ cw[p];
            cw[1 << j] = x;
        end
        x = 1'b0;
        for (int p = 1; p < n; p++) x = x ^ cw[p];
        cw[0] = x;
        return cw;
    endfunction

    function automatic logic [15:0] extract(input int m, input logic [15:0] cw);
        logic [15:0] d;
        int pos;
        d = '0;
        pos = 1;
        for (int i = 0; i < m; i++) begin
            while ((pos & (pos - 1)) == 0) pos++;
            d[i] = cw[pos];
            pos++;
        end
        return d;
    endfunction

    function automatic logic [7:0] to_serial4(input logic [15:0] cw);
        logic [7:0] s;
        for (int k = 0; k < 7; k++) s[7 - k] = cw[k + 1];
        s[0] = cw[0];
        return s;
    endfunction

    // Scoreboard push plus saturating counter model.
    task automatic expect_a(input logic [3:0] d, input logic corr, input logic uncorr, input logic clr);
        exp_q.push_back({uncorr, corr, d});
        if (clr) begin
            c8 = 0; u8 = 0; c2 = 0; u2 = 0;
        end else begin
            if (corr) begin
                if (c8 < 255) c8++;
                if (c2 < 3) c2++;
            end
            if (uncorr) begin
                if (u8 < 255) u8++;
                if (u2 < 3) u2++;
            end
        end
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_corr8"}, {24'd0, corr_a}, c8);
        chk({tag, "_uncorr8"}, {24'd0, uncorr_a}, u8);
        chk({tag, "_corr2"}, {30'd0, corr_b}, c2);
        chk({tag, "_uncorr2"}, {30'd0, uncorr_b}, u2);
    endtask

    // Driver tasks
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_ab(input logic b, input logic sy, input logic cl);
        if_a.bit_in = b; if_a.shift = 1'b1; if_a.sync = sy;
        if_b.bit_in = b; if_b.shift = 1'b1; if_b.sync = sy;
        clr_cnt = cl;
        @(posedge clk);
        #1;
        if_a.shift = 1'b0; if_a.sync = 1'b0;
        if_b.shift = 1'b0; if_b.sync = 1'b0;
        clr_cnt = 1'b0;
    endtask

    // s[7] is sent first (p1), s[0] last (p0).
    task automatic send_serial(input logic [7:0] s, input int gap, input logic sync_first, input logic clr_last);
        for (int k = 7; k >= 0; k--) begin
            if (gap > 0 && k != 7) idle($urandom_range(0, gap));
            drive_ab(s[k], (k == 7) && sync_first, (k == 0) && clr_last);
        end
        chk("latency_valid", {31'd0, if_a.valid}, 1);
    endtask

    task automatic send_c(input logic [15:0] cw, input logic [4:0] d, input logic corr, input logic uncorr, input string tag);
        for (int k = 1; k <= 10; k++) begin
            if_c.bit_in = (k == 10) ? cw[0] : cw[k];
            if_c.shift = 1'b1;
            @(posedge clk);
            #1;
            if_c.shift = 1'b0;
        end
        chk({tag, "_valid"}, {31'd0, if_c.valid}, 1);
        chk({tag, "_data"}, {27'd0, if_c.data_out}, {27'd0, d});
        chk({tag, "_flags"}, {30'd0, if_c.err_uncorr, if_c.err_corr}, {30'd0, uncorr, corr});
    endtask

    // Scoreboard monitor: every valid on the main instance must match a queued frame.
    always @(negedge clk) begin
        if (if_a.valid === 1'b1) begin
            vcount++;
            if (exp_q.size() == 0) begin
                chk("spurious_valid", {31'd0, if_a.valid}, 0);
            end else begin
                chk("frame_a", {26'd0, if_a.err_uncorr, if_a.err_corr, if_a.data_out},
                    {26'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        logic [15:0] cw;
        logic [3:0]  d;
        logic [4:0]  d5;
        int          f, g, vbefore;

        reset = 1'b0;
        clr_cnt = 1'b0;
        if_a.bit_in = 1'b0; if_a.shift = 1'b0; if_a.sync = 1'b0;
        if_b.bit_in = 1'b0; if_b.shift = 1'b0; if_b.sync = 1'b0;
        if_c.bit_in = 1'b0; if_c.shift = 1'b0; if_c.sync = 1'b0;
        idle(3);
        chk("rst_data", {28'd0, if_a.data_out}, 0);
        chk("rst_flags", {29'd0, if_a.valid, if_a.err_corr, if_a.err_uncorr}, 0);
        chk("rst_busy", {31'd0, if_a.busy}, 0);
        check_counts("rst");
        reset = 1'b1;
        idle(2);

        // 1. clean frame
        expect_a(4'b1011, 1'b0, 1'b0, 1'b0);
        send_serial(8'b1010_1010, 0, 1'b0, 1'b0);
        // 2. p5 flipped
        expect_a(4'b1011, 1'b1, 1'b0, 1'b0);
        send_serial(8'b1010_0010, 0, 1'b0, 1'b0);
        idle(1);
        check_counts("t2");
        // 3. p2+p6 flipped: raw data, flags hold afterwards
        expect_a(4'b1111, 1'b0, 1'b1, 1'b0);
        send_serial(8'b1110_1110, 0, 1'b0, 1'b0);
        idle(3);
        chk("hold_data", {28'd0, if_a.data_out}, 32'hF);
        chk("hold_flags", {29'd0, if_a.valid, if_a.err_corr, if_a.err_uncorr}, 1);
        check_counts("t3");
        // 4. p0 flipped
        expect_a(4'b1011, 1'b1, 1'b0, 1'b0);
        send_serial(8'b1010_1011, 0, 1'b0, 1'b0);
        idle(1);

        // 5. partial frame, sync together with the new frame's first bit, gaps
        drive_ab(1'b1, 1'b0, 1'b0);
        drive_ab(1'b0, 1'b0, 1'b0);
        drive_ab(1'b1, 1'b0, 1'b0);
        chk("busy_mid", {31'd0, if_a.busy}, 1);
        vbefore = vcount;
        expect_a(4'b1011, 1'b0, 1'b0, 1'b0);
        send_serial(8'b1010_1010, 3, 1'b1, 1'b0);
        idle(4);
        chk("one_valid", vcount, vbefore + 1);
        chk("busy_idle", {31'd0, if_a.busy}, 0);

        // reset mid-frame
        drive_ab(1'b1, 1'b0, 1'b0);
        drive_ab(1'b1, 1'b0, 1'b0);
        drive_ab(1'b0, 1'b0, 1'b0);
        vbefore = vcount;
        reset = 1'b0;
        c8 = 0; u8 = 0; c2 = 0; u2 = 0;
        #1;
        chk("mid_rst_data", {28'd0, if_a.data_out}, 0);
        chk("mid_rst_flags", {28'd0, if_a.valid, if_a.err_corr, if_a.err_uncorr, if_a.busy}, 0);
        check_counts("mid_rst");
        idle(2);
        reset = 1'b1;
        idle(10);
        chk("no_valid_after_rst", vcount, vbefore);
        expect_a(4'b1011, 1'b0, 1'b0, 1'b0);
        send_serial(8'b1010_1010, 1, 1'b0, 1'b0);

        // 6. saturation of the CW=2 counter, then clears
        for (int i = 0; i < 5; i++) begin
            expect_a(4'b1011, 1'b1, 1'b0, 1'b0);
            send_serial(8'b1010_0010, 0, 1'b0, 1'b0);
        end
        idle(1);
        check_counts("sat");
        clr_cnt = 1'b1;
        c8 = 0; u8 = 0; c2 = 0; u2 = 0;
        idle(1);
        clr_cnt = 1'b0;
        check_counts("clr");
        expect_a(4'b1011, 1'b1, 1'b0, 1'b0);
        send_serial(8'b1010_0010, 0, 1'b0, 1'b0);
        expect_a(4'b1011, 1'b1, 1'b0, 1'b1);
        send_serial(8'b1010_0010, 0, 1'b0, 1'b1);
        idle(1);
        check_counts("clr_wins");

        // random single errors (or none) from the reference encoder
        for (int i = 0; i < 8; i++) begin
            d = 4'($urandom_range(0, 15));
            cw = enc(4, {12'd0, d});
            f = $urandom_range(0, 8);
            if (f < 8) cw[f] = ~cw[f];
            expect_a(d, (f < 8), 1'b0, 1'b0);
            send_serial(to_serial4(cw), 2, 1'b0, 1'b0);
        end
        // random double errors: uncorrectable, raw data delivered
        for (int i = 0; i < 3; i++) begin
            d = 4'($urandom_range(0, 15));
            cw = enc(4, {12'd0, d});
            f = $urandom_range(0, 7);
            g = (f + 1 + $urandom_range(0, 6)) % 8;
            cw[f] = ~cw[f];
            cw[g] = ~cw[g];
            expect_a(extract(4, cw)[3:0], 1'b0, 1'b1, 1'b0);
            send_serial(to_serial4(cw), 1, 1'b0, 1'b0);
        end
        idle(1);
        check_counts("rand");

        // M=5: clean, single error, and S=12 with P=1 (out of range)
        d5 = 5'($urandom_range(0, 31));
        cw = enc(5, {11'd0, d5});
        send_c(cw, d5, 1'b0, 1'b0, "m5_clean");
        cw[7] = ~cw[7];
        send_c(cw, d5, 1'b1, 1'b0, "m5_single");
        d5 = 5'b10110;
        cw = enc(5, {11'd0, d5});
        cw[4] = ~cw[4];
        cw[8] = ~cw[8];
        cw[0] = ~cw[0];
        send_c(cw, d5, 1'b0, 1'b1, "m5_s12");
        chk("m5_uncorr_cnt", {24'd0, uncorr_c}, 1);

        idle(3);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
